// File: rtl/booth_datapath_pkg.sv
// Shared constants for the Booth multiplier: controller state encodings and widths.
// The next-state logic and the datapath both decode state through this package.
package booth_datapath_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/booth_datapath_if.sv
// Bundle between the multiplier controller/top level and the Booth datapath.
interface booth_datapath_if #(parameter int WIDTH = booth_datapath_pkg::WIDTH);
    import booth_datapath_pkg::*;

    logic [1:0]                state;
    logic [CNT_W-1:0]          count;
    logic signed [WIDTH-1:0]   multiplicand;
    logic signed [WIDTH-1:0]   multiplier;
    logic signed [2*WIDTH-1:0] result;
    logic                      op_done;

    modport master (
        output state, count, multiplicand, multiplier,
        input  result, op_done
    );

    modport slave (
        input  state, count, multiplicand, multiplier,
        output result, op_done
    );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the combined {A, Q, q_m1} register.
module booth_step #(
    parameter int WIDTH = 64
) (
    input  logic signed [WIDTH:0]   a_in,
    input  logic        [WIDTH-1:0] q_in,
    input  logic                    qm1_in,
    input  logic signed [WIDTH-1:0] m_in,
    output logic signed [WIDTH:0]   a_out,
    output logic        [WIDTH-1:0] q_out,
    output logic                    qm1_out
);

    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] sum;

    assign m_ext = {m_in[WIDTH-1], m_in};

    always_comb begin
        sum = a_in;
        case ({q_in[0], qm1_in})
            2'b01:   sum = a_in + m_ext;
            2'b10:   sum = a_in - m_ext;
            default: sum = a_in;
        endcase
    end

    // A's sign bit is replicated; A's LSB falls into Q's MSB.
    assign a_out   = {sum[WIDTH], sum[WIDTH:1]};
    assign q_out   = {sum[0], q_in[WIDTH-1:1]};
    assign qm1_out = q_in[0];

endmodule

// File: rtl/booth_datapath.sv
// Radix-2 Booth signed multiplier datapath: operand/accumulator registers advanced
// one Booth step per EXEC cycle under the external controller's state and count.
module booth_datapath #(
    parameter int WIDTH = booth_datapath_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    booth_datapath_if.slave bus
);
    import booth_datapath_pkg::*;

    logic signed [WIDTH-1:0] m_reg;
    logic signed [WIDTH:0]   a_reg;
    logic        [WIDTH-1:0] q_reg;
    logic                    qm1_reg;

    logic signed [WIDTH:0]   a_nxt;
    logic        [WIDTH-1:0] q_nxt;
    logic                    qm1_nxt;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_in    (a_reg),
        .q_in    (q_reg),
        .qm1_in  (qm1_reg),
        .m_in    (m_reg),
        .a_out   (a_nxt),
        .q_out   (q_nxt),
        .qm1_out (qm1_nxt)
    );

    // A is one bit wider than M so that M = -2^(WIDTH-1) cannot overflow on subtract.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            qm1_reg <= 1'b0;
        end else begin
            case (bus.state)
                ST_IDLE: begin
                    m_reg   <= bus.multiplicand;
                    q_reg   <= bus.multiplier;
                    a_reg   <= '0;
                    qm1_reg <= 1'b0;
                end
                ST_EXEC: begin
                    if (bus.count < CNT_W'(WIDTH)) begin
                        a_reg   <= a_nxt;
                        q_reg   <= q_nxt;
                        qm1_reg <= qm1_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result  = {a_reg[WIDTH-1:0], q_reg};
    assign bus.op_done = (bus.state == ST_DONE);

endmodule
